// File: rtl/deinterleaver_top.sv
// -----------------------------------------------------------------------------
// deinterleaver_top
//   Receive-side block deinterleaver for the WiMAX OFDM PHY. It is the exact
//   inverse of interleaver_top. One interleaved FEC block of Ncbps coded bits
//   arrives serially. Each bit is written into a ping-pong bank at its original
//   position. A full bank is then read out in natural order 0..Ncbps-1.
//   With two banks, one block can fill while the other drains, so the block
//   sustains 1 bit/cycle in and out.
//
// Ports
//   clk            in   clock, rising edge
//   resetN         in   asynchronous active-low reset
//   data_in        in   interleaved input bit
//   valid_in       in   upstream offers data_in
//   ready_out      out  a bit can be accepted (registered)
//   data_out       out  deinterleaved output bit
//   valid_out      out  data_out is valid
//   ready_in       in   downstream takes data_out
//   data_out_index out  original bit index k of data_out
//
// Per-bank state (derived from full/wr_sel/rd_sel/counters, not encoded)
//   state    | meaning
//   EMPTY    | not full, and not being written past position 0
//   FILLING  | wr_sel points here and at least one bit is written
//   FULL     | complete block waiting to be read
//   DRAINING | rd_sel points here, full, and at least one bit is read
// -----------------------------------------------------------------------------
module deinterleaver_top #(
    parameter int Ncbps = 192,
    parameter int Ncpc  = 2,
    parameter int s     = Ncpc / 2,
    parameter int d     = 16
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     data_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic                     data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(Ncbps)-1:0] data_out_index
);

    localparam int IDX_W = $clog2(Ncbps);
    localparam int ROWS  = Ncbps / d;
    localparam int R_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int C_W   = (d > 1) ? $clog2(d) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Ncbps - 1);
    localparam logic [R_W-1:0]   ROW_LAST = R_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] D_STEP   = IDX_W'(d);

    if (s != 1) begin : g_bad_s
        $error("deinterleaver_top: only s == 1 is supported");
    end
    if ((Ncbps % d) != 0) begin : g_bad_ncbps
        $error("deinterleaver_top: Ncbps must be a multiple of d");
    end

    logic [Ncbps-1:0] bank [0:1];
    logic [1:0]       full;
    logic [1:0]       full_next;
    logic             wr_sel;
    logic             rd_sel;
    logic             wr_sel_next;
    logic             rd_sel_next;
    logic [IDX_W-1:0] wr_cnt;
    logic [R_W-1:0]   row;
    logic [C_W-1:0]   col;
    logic [IDX_W-1:0] wr_addr;
    logic [IDX_W-1:0] rd_cnt;
    logic             ready_q;

    logic wr_fire;
    logic rd_fire;
    logic wr_done;
    logic rd_done;

    assign wr_fire = valid_in & ready_q;
    assign rd_fire = full[rd_sel] & ready_in;
    assign wr_done = wr_fire && (wr_cnt == LAST_IDX);
    assign rd_done = rd_fire && (rd_cnt == LAST_IDX);

    // A completing write and a completing read always target different
    // banks, because the writer is never pointed at a full bank. Both
    // updates can therefore be applied independently.
    always_comb begin
        full_next = full;
        if (wr_done) full_next[wr_sel] = 1'b1;
        if (rd_done) full_next[rd_sel] = 1'b0;
        wr_sel_next = wr_sel ^ wr_done;
        rd_sel_next = rd_sel ^ rd_done;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            full    <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            wr_cnt  <= '0;
            row     <= '0;
            col     <= '0;
            wr_addr <= '0;
            rd_cnt  <= '0;
            ready_q <= 1'b0;
        end else begin
            full    <= full_next;
            wr_sel  <= wr_sel_next;
            rd_sel  <= rd_sel_next;
            // Look ahead at the bank the writer will use next cycle. This
            // lets ready drop on the edge that fills the second bank, and
            // rise on the edge that frees it.
            ready_q <= ~full_next[wr_sel_next];

            if (wr_fire) begin
                if (wr_done) begin
                    wr_cnt  <= '0;
                    row     <= '0;
                    col     <= '0;
                    wr_addr <= '0;
                end else begin
                    wr_cnt <= wr_cnt + IDX_W'(1);
                    // The address is d*row + col. It steps by d down a
                    // column and restarts at the next column when row wraps.
                    if (row == ROW_LAST) begin
                        row     <= '0;
                        col     <= col + C_W'(1);
                        wr_addr <= IDX_W'(col) + IDX_W'(1);
                    end else begin
                        row     <= row + R_W'(1);
                        wr_addr <= wr_addr + D_STEP;
                    end
                end
            end

            if (rd_fire) begin
                rd_cnt <= rd_done ? '0 : rd_cnt + IDX_W'(1);
            end
        end
    end

    // The storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank[wr_sel][wr_addr] <= data_in;
        end
    end

    assign ready_out      = ready_q;
    assign valid_out      = full[rd_sel];
    // Gate the data with valid so the output reads 0 whenever nothing is
    // presented, including during reset.
    assign data_out       = full[rd_sel] & bank[rd_sel][rd_cnt];
    assign data_out_index = rd_cnt;

endmodule
